// File: rtl/snake_matrix_scan.sv
// ============================================================================
// Module   : snake_matrix_scan
// Brief    : Latches a list of up to 8 cell indices once per frame and
//            row-scans it onto an 8x8 LED matrix with inter-row blanking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module snake_matrix_scan #(
    parameter int ROW_DWELL    = 25000,
    parameter int BLANK_CYC    = 50,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [47:0] snake_index,
    input  logic [3:0]  snake_len,
    input  logic        snake_en,
    output logic [7:0]  row_n,
    output logic [7:0]  col,
    output logic        frame_start
);

    localparam int c_MAX_CYC = (ROW_DWELL > BLANK_CYC) ? ROW_DWELL : BLANK_CYC;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);
    localparam int c_BLK_W   = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_row_ptr;
    logic [47:0]          r_shadow;
    logic [3:0]           r_len;
    logic                 r_en;
    logic [c_BLK_W-1:0]   r_blink_cnt;
    logic                 r_blink_phase;
    logic                 r_first_blank;
    logic [63:0]          r_bitmap;
    logic [63:0]          w_bitmap;
    logic [63:0]          w_cur_bitmap;

    // Head (entry 0) drops out during the dark blink phase; other entries
    // landing on the same cell still light it.
    always_comb begin
        w_bitmap = '0;
        for (int i = 0; i < 8; i++) begin
            if ((4'(i) < r_len) && !(i == 0 && r_en && r_blink_phase)) begin
                w_bitmap[r_shadow[6*i +: 6]] = 1'b1;
            end
        end
    end

    // With a single blank cycle the bitmap register is written on the same
    // edge that enters DRIVE, so the freshly decoded value is forwarded.
    assign w_cur_bitmap = r_first_blank ? w_bitmap : r_bitmap;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= S_LOAD;
            r_cnt         <= '0;
            r_row_ptr     <= '0;
            r_shadow      <= '0;
            r_len         <= '0;
            r_en          <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_first_blank <= 1'b0;
            r_bitmap      <= '0;
            row_n         <= 8'hFF;
            col           <= 8'h00;
            frame_start   <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    r_shadow      <= snake_index;
                    r_len         <= (snake_len > 4'd8) ? 4'd8 : snake_len;
                    r_en          <= snake_en;
                    if (r_blink_cnt == c_BLK_W'(BLINK_FRAMES - 1)) begin
                        r_blink_cnt   <= '0;
                        r_blink_phase <= ~r_blink_phase;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + c_BLK_W'(1);
                    end
                    frame_start   <= 1'b1;
                    r_first_blank <= 1'b1;
                    r_cnt         <= '0;
                    row_n         <= 8'hFF;
                    col           <= 8'h00;
                    r_state       <= S_BLANK;
                end
                S_BLANK: begin
                    if (r_first_blank) begin
                        r_bitmap      <= w_bitmap;
                        r_first_blank <= 1'b0;
                    end
                    if (r_cnt == c_CNT_W'(BLANK_CYC - 1)) begin
                        r_cnt   <= '0;
                        row_n   <= ~(8'h01 << r_row_ptr);
                        col     <= w_cur_bitmap[{r_row_ptr, 3'b000} +: 8];
                        r_state <= S_DRIVE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == c_CNT_W'(ROW_DWELL - 1)) begin
                        r_cnt <= '0;
                        row_n <= 8'hFF;
                        col   <= 8'h00;
                        if (r_row_ptr == 3'd7) begin
                            r_row_ptr <= '0;
                            r_state   <= S_LOAD;
                        end else begin
                            r_row_ptr <= r_row_ptr + 3'd1;
                            r_state   <= S_BLANK;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                    row_n   <= 8'hFF;
                    col     <= 8'h00;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_snake_matrix_scan.sv
// ============================================================================
// Module   : tb_snake_matrix_scan
// Brief    : Directed and randomized bench for snake_matrix_scan against a
//            frame-position reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_snake_matrix_scan;

    localparam int ROW_DWELL    = 4;
    localparam int BLANK_CYC    = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int ROW_SLOT     = BLANK_CYC + ROW_DWELL;
    localparam int FRAME        = 1 + 8 * ROW_SLOT;

    logic        sys_clk     = 1'b0;
    logic        sys_rst_n   = 1'b0;
    logic [47:0] snake_index = '0;
    logic [3:0]  snake_len   = '0;
    logic        snake_en    = 1'b0;
    logic [7:0]  row_n;
    logic [7:0]  col;
    logic        frame_start;

    int          checks  = 0;
    int          errors  = 0;
    int          k       = 0;
    int          n_loads = 0;
    logic [63:0] exp_bm  = '0;

    snake_matrix_scan #(
        .ROW_DWELL    (ROW_DWELL),
        .BLANK_CYC    (BLANK_CYC),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .snake_index (snake_index),
        .snake_len   (snake_len),
        .snake_en    (snake_en),
        .row_n       (row_n),
        .col         (col),
        .frame_start (frame_start)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // Lit cells for the frame just loaded; blink phase flips after every
    // BLINK_FRAMES loads, counting from reset.
    task automatic build_model();
        int   eff;
        logic dark;
        eff    = (snake_len > 4'd8) ? 8 : int'(snake_len);
        dark   = ((n_loads / BLINK_FRAMES) % 2) == 1;
        exp_bm = '0;
        for (int i = 0; i < eff; i++) begin
            if (!(i == 0 && snake_en && dark))
                exp_bm[snake_index[6*i +: 6]] = 1'b1;
        end
    endtask

    task automatic step();
        int         q;
        int         row;
        logic [7:0] er;
        logic [7:0] ec;
        @(posedge sys_clk);
        #1;
        k++;
        q = (k - 1) % FRAME;
        if (q == 0) begin
            n_loads++;
            build_model();
        end
        er = 8'hFF;
        ec = 8'h00;
        if (q < FRAME - 1 && (q % ROW_SLOT) >= BLANK_CYC) begin
            row = q / ROW_SLOT;
            er  = ~(8'h01 << row);
            ec  = exp_bm[row*8 +: 8];
        end
        check8("row_n", row_n, er);
        check8("col", col, ec);
        check8("frame_start", {7'd0, frame_start}, {7'd0, q == 0});
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic release_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        k         = 0;
        n_loads   = 0;
    endtask

    initial begin
        // Reset state, then diagonal pattern ready for the first load
        snake_index = {6'd63, 6'd54, 6'd45, 6'd36, 6'd27, 6'd18, 6'd9, 6'd0};
        snake_len   = 4'd8;
        #12;
        check8("rst_row_n", row_n, 8'hFF);
        check8("rst_col", col, 8'h00);
        check8("rst_fs", {7'd0, frame_start}, 8'h00);
        release_reset();
        run_steps(FRAME);

        // Three valid entries with garbage beyond len
        snake_index = {{5{6'd63}}, 6'd2, 6'd1, 6'd0};
        snake_len   = 4'd3;
        run_steps(FRAME);

        snake_len = 4'd0;
        run_steps(FRAME);

        snake_index = {6'd7, 6'd14, 6'd21, 6'd28, 6'd35, 6'd42, 6'd49, 6'd56};
        snake_len   = 4'd15;
        run_steps(FRAME);

        // Change inputs mid-frame in row 3 DRIVE; must only show next frame
        snake_index = {6'd5, 6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd47, 6'd54};
        snake_len   = 4'd8;
        run_steps(3 * ROW_SLOT + BLANK_CYC + 1);
        snake_index = {8{6'd31}};
        snake_len   = 4'd1;
        run_steps(FRAME - (3 * ROW_SLOT + BLANK_CYC + 1) + FRAME);

        // Head blink with a unique head, then with the head cell duplicated
        snake_en    = 1'b1;
        snake_index = {{5{6'd0}}, 6'd30, 6'd20, 6'd10};
        snake_len   = 4'd3;
        run_steps(6 * FRAME);
        snake_index = {{5{6'd0}}, 6'd30, 6'd10, 6'd10};
        run_steps(4 * FRAME);
        snake_en = 1'b0;
        snake_index = {{5{6'd0}}, 6'd30, 6'd20, 6'd10};
        run_steps(2 * FRAME);

        // Randomized frames with random mid-frame updates
        for (int f = 0; f < 8; f++) begin
            int cut;
            snake_index = {16'($urandom), 32'($urandom)};
            snake_len   = 4'($urandom_range(0, 15));
            snake_en    = 1'($urandom_range(0, 1));
            cut         = int'($urandom_range(1, FRAME - 1));
            run_steps(cut);
            snake_index = {16'($urandom), 32'($urandom)};
            snake_len   = 4'($urandom_range(0, 15));
            snake_en    = 1'($urandom_range(0, 1));
            run_steps(FRAME - cut);
        end

        // Asynchronous reset in the middle of a DRIVE slot
        run_steps(3 * ROW_SLOT + BLANK_CYC + 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check8("async_row_n", row_n, 8'hFF);
        check8("async_col", col, 8'h00);
        check8("async_fs", {7'd0, frame_start}, 8'h00);
        snake_index = {6'd63, 6'd54, 6'd45, 6'd36, 6'd27, 6'd18, 6'd9, 6'd0};
        snake_len   = 4'd8;
        snake_en    = 1'b1;
        release_reset();
        run_steps(3 * FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
